rhythm_lane_judge: RTL
======================

# rhythm_lane_judge

Parametrised multi-lane judgment engine; successor to the fixed 8-key score calculator in the rhythm-game top level. Holds one pending note per lane, timestamps key presses against the free-running game timer, and classifies each press as PERFECT / GOOD or each expired note as MISS. Accumulates a saturating score, a combo count and a max combo. Sits between the pattern/input managers and the seven-segment score decoder.

## Interface
- LANES, 8, number of key lanes
- TIME_W, 10, game timer / note timestamp width
- PERFECT_WIN, 1, max |Δt| for PERFECT (timer units)
- GOOD_WIN, 3, max |Δt| for GOOD; must be ≥ PERFECT_WIN and < 2^(TIME_W-1)
- PERFECT_PTS, 3, points per PERFECT
- GOOD_PTS, 1, points per GOOD
- SCORE_W, 11, score width
- COMBO_W, 8, combo width
- CLOCK50M  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- game_timer  in  TIME_W  current game time, wraps modulo 2^TIME_W
- note_valid  in  1  note load request
- note_lane_mask  in  LANES  lanes receiving the note
- note_time  in  TIME_W  target hit time
- note_ready  out  1  high when every lane in note_lane_mask is empty
- key  in  LANES  debounced key levels, 1 = pressed
- hit_perfect  out  LANES  1-cycle pulse per lane
- hit_good  out  LANES  1-cycle pulse per lane
- miss  out  LANES  1-cycle pulse per lane
- lane_pending  out  LANES  slot-occupied flags
- score  out  SCORE_W  accumulated score
- combo  out  COMBO_W  current combo
- max_combo  out  COMBO_W  best combo since reset

## Operation
- Per lane: slot {pending, time}. Load when note_valid && note_ready: each masked lane sets pending, time = note_time. note_ready is combinational from registered pending bits; a slot freed in the same cycle does not count as empty.
- Δt = game_timer − time, TIME_W-bit modular subtraction interpreted as signed; wrap-around is handled inherently.
- Press = key high && key_q low (key_q: previous sample per lane).
- Pending lane, press: |Δt| ≤ PERFECT_WIN → PERFECT; ≤ GOOD_WIN → GOOD; clear slot. Press with Δt < −GOOD_WIN, or no pending note → ignored, no state change.
- Pending lane, Δt > GOOD_WIN → MISS, clear slot. Checked every cycle; evaluated before press in the same lane, so a late press yields MISS only.
- Per cycle: H = count of PERFECT+GOOD, any_miss = |miss.
- combo_next = any_miss ? 0 : sat(combo + H); max_combo = max(max_combo, combo_next).
- score += Σ points of the cycle's hits (hits count even when a miss occurs in the same cycle); saturates at 2^SCORE_W−1, never wraps.
- Combo saturates at 2^COMBO_W−1.
- A note loaded already late (Δt > GOOD_WIN) misses the next cycle.

## Timing
- Reset values: score, combo, max_combo, hit_*, miss, lane_pending = 0; key_q = all 1s (a key held through reset produces no press).
- Latency: key first sampled high at edge k → hit pulse, score/combo update visible after edge k. Same for miss: detected at edge k, pulse after edge k.
- Loaded note visible in lane_pending the cycle after the load edge.
- Pulses last exactly one cycle; all outputs registered except note_ready.
- Reset mid-operation: all slots discarded, no pulses emitted.

## Configuration
- RHYTHM_COMBO_BONUS_EN defined: each hit scored in a cycle where combo (pre-update) ≥ 10 earns double points (still saturating).
- Undefined: points always PERFECT_PTS / GOOD_PTS; no comparator logic built.

## Test plan
- Load lane 2 at time 100; press at timer 101 → hit_perfect[2] pulse, score 3, combo 1, lane_pending[2] = 0.
- Load lane 0 at time 100; no press; timer reaches 104 → miss[0] pulse, combo 0, score unchanged.
- Load lane 5 at time 1022; press at timer 1 (wrapped, Δt = +3) → hit_good[5], score +1.
- Lanes 0 and 1 pending at 50, press both at timer 50 while lane 3 misses same cycle → score +6, combo 0, max_combo retained.
- note_valid with mask overlapping an occupied lane → note_ready 0, no slot altered; press at timer 90 on note 200 ignored, slot stays pending.
- With macro: 10 consecutive PERFECTs then one more → final hit adds 6 (score 36); without macro adds 3 (score 33); score saturates at 2047.

Source files
------------

// File: rtl/rhythm_lane_judge.sv
// rtl/rhythm_lane_judge.sv - multi-lane note judge: PERFECT/GOOD/MISS, saturating score and combo
// Optional RHYTHM_COMBO_BONUS_EN: double points for hits while combo >= 10.
module rhythm_lane_judge #(
  parameter int LANES       = 8,
  parameter int TIME_W      = 10,
  parameter int PERFECT_WIN = 1,
  parameter int GOOD_WIN    = 3,
  parameter int PERFECT_PTS = 3,
  parameter int GOOD_PTS    = 1,
  parameter int SCORE_W     = 11,
  parameter int COMBO_W     = 8
) (
  input  logic               CLOCK50M,
  input  logic               reset,
  input  logic [TIME_W-1:0]  game_timer,
  input  logic               note_valid,
  input  logic [LANES-1:0]   note_lane_mask,
  input  logic [TIME_W-1:0]  note_time,
  output logic               note_ready,
  input  logic [LANES-1:0]   key,
  output logic [LANES-1:0]   hit_perfect,
  output logic [LANES-1:0]   hit_good,
  output logic [LANES-1:0]   miss,
  output logic [LANES-1:0]   lane_pending,
  output logic [SCORE_W-1:0] score,
  output logic [COMBO_W-1:0] combo,
  output logic [COMBO_W-1:0] max_combo
);

  localparam int CNT_W  = $clog2(LANES + 1);
  localparam int ACC_W  = SCORE_W + CNT_W + 8;
  localparam int CSUM_W = COMBO_W + CNT_W;
  localparam logic signed [TIME_W-1:0] PERF_S = signed'(TIME_W'(PERFECT_WIN));
  localparam logic signed [TIME_W-1:0] GOOD_S = signed'(TIME_W'(GOOD_WIN));
  localparam logic [ACC_W-1:0]  SCORE_MAX = {{(ACC_W-SCORE_W){1'b0}}, {SCORE_W{1'b1}}};
  localparam logic [CSUM_W-1:0] COMBO_MAX = {{CNT_W{1'b0}}, {COMBO_W{1'b1}}};

  logic [LANES-1:0]   pending_q, pending_d;
  logic [TIME_W-1:0]  time_q [LANES];
  logic [TIME_W-1:0]  time_d [LANES];
  logic [LANES-1:0]   key_q;
  logic [LANES-1:0]   perf_q, perf_d;
  logic [LANES-1:0]   good_q, good_d;
  logic [LANES-1:0]   miss_q, miss_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [COMBO_W-1:0] combo_q, combo_d;
  logic [COMBO_W-1:0] max_q, max_d;

  logic [LANES-1:0]  press;
  logic              load;
  logic [CNT_W-1:0]  hits;
  logic [ACC_W-1:0]  add;
  logic [ACC_W-1:0]  score_sum;
  logic [CSUM_W-1:0] combo_sum;

  assign press      = key & ~key_q;
  assign note_ready = ~|(note_lane_mask & pending_q);
  assign load       = note_valid & note_ready;

  // Modular difference read as signed makes timer wrap transparent.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [TIME_W-1:0] dt;
    logic in_good, in_perf;
    assign dt        = signed'(game_timer - time_q[g]);
    assign in_good   = (dt >= -GOOD_S) && (dt <= GOOD_S);
    assign in_perf   = (dt >= -PERF_S) && (dt <= PERF_S);
    assign miss_d[g] = pending_q[g] && (dt > GOOD_S);
    assign perf_d[g] = pending_q[g] && press[g] && !miss_d[g] && in_perf;
    assign good_d[g] = pending_q[g] && press[g] && !miss_d[g] && in_good && !in_perf;
  end

  always_comb begin
    pending_d = (pending_q & ~(perf_d | good_d | miss_d)) | (load ? note_lane_mask : '0);
    for (int i = 0; i < LANES; i++) begin
      time_d[i] = (load && note_lane_mask[i]) ? note_time : time_q[i];
    end
  end

  always_comb begin
    hits = '0;
    add  = '0;
    for (int i = 0; i < LANES; i++) begin
      if (perf_d[i]) begin
        hits = hits + CNT_W'(1);
        add  = add + ACC_W'(PERFECT_PTS);
      end else if (good_d[i]) begin
        hits = hits + CNT_W'(1);
        add  = add + ACC_W'(GOOD_PTS);
      end
    end
`ifdef RHYTHM_COMBO_BONUS_EN
    if (combo_q >= COMBO_W'(10)) add = add << 1;
`endif
    score_sum = ACC_W'(score_q) + add;
    score_d   = (score_sum > SCORE_MAX) ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
    combo_sum = CSUM_W'(combo_q) + CSUM_W'(hits);
    if (|miss_d)                  combo_d = '0;
    else if (combo_sum > COMBO_MAX) combo_d = {COMBO_W{1'b1}};
    else                          combo_d = combo_sum[COMBO_W-1:0];
    max_d = (combo_d > max_q) ? combo_d : max_q;
  end

  // key_q resets high so a key held through reset is not seen as a press.
  always_ff @(posedge CLOCK50M or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
      key_q     <= '1;
      perf_q    <= '0;
      good_q    <= '0;
      miss_q    <= '0;
      score_q   <= '0;
      combo_q   <= '0;
      max_q     <= '0;
      for (int i = 0; i < LANES; i++) time_q[i] <= '0;
    end else begin
      pending_q <= pending_d;
      key_q     <= key;
      perf_q    <= perf_d;
      good_q    <= good_d;
      miss_q    <= miss_d;
      score_q   <= score_d;
      combo_q   <= combo_d;
      max_q     <= max_d;
      for (int i = 0; i < LANES; i++) time_q[i] <= time_d[i];
    end
  end

  assign hit_perfect  = perf_q;
  assign hit_good     = good_q;
  assign miss         = miss_q;
  assign lane_pending = pending_q;
  assign score        = score_q;
  assign combo        = combo_q;
  assign max_combo    = max_q;

endmodule
